out_drain: RTL and testbench

- Downstream neighbour of macarray: after the MAC array has written the T x M result into OUT_MEM (64-bit words, 4 x 16-bit lanes), out_drain reads OUT_MEM back.
- It unpacks the valid elements in row-major order and streams them one per beat over a valid/ready interface to the host or a checker.
- It owns the OUT_MEM read port only while BUSY. External muxing gives macarray the port otherwise.

---
 rtl/out_drain_pkg.sv | 17 +
 rtl/out_drain_addr_gen.sv | 55 +++++
 rtl/out_drain.sv | 99 +++++++++
 tb/tb_out_drain.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_drain_pkg.sv
// out_drain_pkg: FSM states, geometry constants, MNT field slices and the
// dimension clamp shared by out_drain and its address generator.
package out_drain_pkg;
  typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DONE_ST} state_e;
  localparam int LANES = 4;
  localparam int ROW_STRIDE = 8;
  localparam int MAX_DIM = 8;
  localparam int M_HI = 11;
  localparam int M_LO = 8;
  localparam int N_HI = 7;
  localparam int N_LO = 4;
  localparam int T_HI = 3;
  localparam int T_LO = 0;
  function automatic logic [3:0] clamp_dim(input logic [3:0] f);
    return (f > 4'(MAX_DIM)) ? 4'(MAX_DIM) : f;
  endfunction
endpackage

// File: rtl/out_drain_addr_gen.sv
// out_drain_addr_gen: row/column-block/lane counters, OUT_MEM address,
// lane limit of the current word and last-element flags.
module out_drain_addr_gen
  import out_drain_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          adv,
  input  logic [3:0]    m,
  input  logic [3:0]    t,
  output logic [AW-1:0] addr,
  output logic [2:0]    row,
  output logic [2:0]    col,
  output logic [1:0]    lane,
  output logic [1:0]    lane_max,
  output logic          last_lane,
  output logic          last_word
);
  logic [3:0] m_q, t_q, rem, t_m1;
  logic [2:0] r_q;
  logic [1:0] lane_q;
  logic       cb_q, cb_last;
  // Lanes left in this column block; a full block ends at lane 3.
  assign rem = m_q - {1'b0, cb_q, 2'b00};
  assign lane_max = (rem > 4'd3) ? 2'd3 : 2'(rem - 4'd1);
  assign last_lane = lane_q == lane_max;
  assign cb_last = cb_q || m_q <= 4'(LANES);
  assign t_m1 = t_q - 4'd1;
  assign last_word = ({1'b0, r_q} == t_m1) && cb_last;
  assign addr = AW'(32'(cb_q) * ROW_STRIDE + 32'(r_q));
  assign row = r_q;
  assign col = {cb_q, lane_q};
  assign lane = lane_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      m_q <= '0;
      t_q <= '0;
      r_q <= '0;
      cb_q <= 1'b0;
      lane_q <= '0;
    end else if (load) begin
      m_q <= clamp_dim(m);
      t_q <= clamp_dim(t);
      r_q <= '0;
      cb_q <= 1'b0;
      lane_q <= '0;
    end else if (adv) begin
      lane_q <= last_lane ? 2'd0 : lane_q + 2'd1;
      cb_q <= last_lane ? !cb_last : cb_q;
      r_q <= (last_lane && cb_last) ? r_q + 3'd1 : r_q;
    end
endmodule

// File: rtl/out_drain.sv
// out_drain: reads the T x M result back from OUT_MEM and streams it row-major,
// one element per valid/ready beat. OUT_DRAIN_PAD_CHECK_EN adds a sticky ERR output.
module out_drain
  import out_drain_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 4,
  parameter int RD_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [11:0]   MNT,
  output logic          EN_O,
  output logic          RW_O,
  output logic [AW-1:0] ADDR_O,
  input  logic [4*DW-1:0] RDATA_O,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [DW-1:0] OUT_DATA,
  output logic [2:0]    OUT_ROW,
  output logic [2:0]    OUT_COL,
  output logic          OUT_LAST,
  output logic          BUSY,
  output logic          DONE
`ifdef OUT_DRAIN_PAD_CHECK_EN
  ,
  output logic          ERR
`endif
);
  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d, lane, lane_max;
  logic [3:0][DW-1:0] wbuf_q;
  logic [AW-1:0] addr_q, gen_addr;
  logic last_lane, last_word, accept, empty, hs, latch, unused_n;
  assign unused_n = ^MNT[N_HI:N_LO];
  assign accept = START && state_q == IDLE;
  assign empty = MNT[M_HI:M_LO] == '0 || MNT[T_HI:T_LO] == '0;
  assign hs = OUT_VALID && OUT_READY;
  assign latch = state_q == WAIT && cnt_q == 2'(RD_LAT - 1);
  out_drain_addr_gen #(.AW(AW)) u_gen (
    .clk(CLK), .rst(RST), .load(accept), .adv(hs),
    .m(MNT[M_HI:M_LO]), .t(MNT[T_HI:T_LO]),
    .addr(gen_addr), .row(OUT_ROW), .col(OUT_COL), .lane(lane),
    .lane_max(lane_max), .last_lane(last_lane), .last_word(last_word)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    case (state_q)
      IDLE: if (START) state_d = empty ? DONE_ST : READ;
      READ: state_d = WAIT;
      WAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (latch) state_d = EMIT;
      end
      EMIT: if (hs && last_lane) state_d = last_word ? DONE_ST : READ;
      default: state_d = IDLE;
    endcase
  end
  // The address is only driven fresh during READ; otherwise the last one is held.
  assign EN_O = state_q == READ;
  assign RW_O = 1'b0;
  assign ADDR_O = EN_O ? gen_addr : addr_q;
  assign OUT_VALID = state_q == EMIT;
  assign OUT_DATA = wbuf_q[~lane];
  assign OUT_LAST = OUT_VALID && last_lane && last_word;
  assign BUSY = state_q inside {READ, WAIT, EMIT};
  assign DONE = state_q == DONE_ST;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wbuf_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= ADDR_O;
      if (latch) wbuf_q <= RDATA_O;
    end
`ifdef OUT_DRAIN_PAD_CHECK_EN
  logic [3:0][DW-1:0] rd;
  logic err_q, pad_bad;
  assign rd = RDATA_O;
  always_comb begin
    pad_bad = 1'b0;
    for (int i = 0; i < LANES; i++) pad_bad = pad_bad || (2'(i) > lane_max && rd[3-i] != '0);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) err_q <= 1'b0;
    else if (accept) err_q <= 1'b0;
    else if (latch && pad_bad) err_q <= 1'b1;
  assign ERR = err_q;
`else
  logic unused_pad;
  assign unused_pad = ^lane_max;
`endif
endmodule

// File: tb/tb_out_drain.sv
// tb_out_drain: directed bench for out_drain with a one-cycle-latency OUT_MEM model.
module tb_out_drain;
  logic clk = 0, rst = 1, start = 0, ready = 1;
  logic [11:0] mnt = '0;
  logic en, rw, valid, last, busy, done;
  logic [3:0] addr;
  logic [63:0] rdata = '0;
  logic [15:0] data;
  logic [2:0] row, col;
`ifdef OUT_DRAIN_PAD_CHECK_EN
  logic err;
`endif
  int passed = 0, total = 0, cyc = 0, done_cnt = 0, done_cyc = 0, last_cyc = 0;
  logic [63:0] mem [16];
  logic en_prev = 0;
  logic [3:0] addr_prev = '0;
  int q_addr[$];
  logic [2:0] q_row[$], q_col[$];
  logic [15:0] q_data[$];
  logic q_last[$];

  always #5 clk = ~clk;

  out_drain dut (
    .CLK(clk), .RST(rst), .START(start), .MNT(mnt), .EN_O(en), .RW_O(rw),
    .ADDR_O(addr), .RDATA_O(rdata), .OUT_VALID(valid), .OUT_READY(ready),
    .OUT_DATA(data), .OUT_ROW(row), .OUT_COL(col), .OUT_LAST(last),
    .BUSY(busy), .DONE(done)
`ifdef OUT_DRAIN_PAD_CHECK_EN
    , .ERR(err)
`endif
  );

  function automatic logic [15:0] ev(int a, int l);
    return 16'(32'hA000 + a * 16 + l);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Read data is only valid in the cycle after EN_O, garbage otherwise.
  always @(negedge clk) begin
    if (en) q_addr.push_back(int'(addr));
    if (valid && ready) begin
      q_row.push_back(row);
      q_col.push_back(col);
      q_data.push_back(data);
      q_last.push_back(last);
      if (last) last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    rdata <= en_prev ? mem[addr_prev] : 64'hDEAD_BEEF_DEAD_BEEF;
    en_prev <= en;
    addr_prev <= addr;
  end

  task clear();
    q_addr.delete(); q_row.delete(); q_col.delete(); q_data.delete(); q_last.delete();
    done_cnt = 0;
  endtask

  task pulse_start(input logic [11:0] m, output int s);
    @(posedge clk); #1;
    mnt = m; start = 1; s = cyc;
    @(posedge clk); #1;
    start = 0;
  endtask

  task wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task test_reset();
    #1;
    total++;
    if ({en, rw, addr, valid, data, row, col, last, busy, done} !== '0)
      $display("FAIL reset_outputs got %0h want 0", {en, rw, addr, valid, data, row, col, last, busy, done});
    else passed++;
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;
    total++;
    if ({en, valid, busy, done} !== 4'b0) $display("FAIL idle_after_reset got %b want 0000", {en, valid, busy, done});
    else passed++;
  endtask

  task test_444();
    int s, s2;
    logic [22:0] exp;
    clear();
    pulse_start(12'h444, s);
    total++;
    if (busy !== 1'b1) $display("FAIL busy_444 got %b want 1", busy); else passed++;
    repeat (3) @(posedge clk);
    #1;
    pulse_start(12'h111, s2);
    wait_done(100);
    total++;
    if (done_cnt !== 1) $display("FAIL done_count_444 got %0d want 1", done_cnt); else passed++;
    total++;
    if (q_addr.size() !== 4) $display("FAIL addr_count_444 got %0d want 4", q_addr.size());
    else begin
      passed++;
      for (int k = 0; k < 4; k++) begin
        total++;
        if (q_addr[k] !== k) $display("FAIL addr_444[%0d] got %0d want %0d", k, q_addr[k], k); else passed++;
      end
    end
    total++;
    if (q_data.size() !== 16) $display("FAIL beat_count_444 got %0d want 16", q_data.size());
    else begin
      passed++;
      total++;
      if (q_data[0] !== 16'hA000) $display("FAIL first_data_444 got %h want a000", q_data[0]); else passed++;
      for (int k = 0; k < 16; k++) begin
        exp = {3'(k / 4), 3'(k % 4), ev(k / 4, k % 4), k == 15};
        total++;
        if ({q_row[k], q_col[k], q_data[k], q_last[k]} !== exp)
          $display("FAIL beat_444[%0d] got %h want %h", k, {q_row[k], q_col[k], q_data[k], q_last[k]}, exp);
        else passed++;
      end
    end
    total++;
    if (done_cyc !== s + 25) $display("FAIL done_time_444 got %0d want %0d", done_cyc - s, 25); else passed++;
    total++;
    if (last_cyc !== done_cyc - 1) $display("FAIL last_time_444 got %0d want %0d", last_cyc, done_cyc - 1); else passed++;
  endtask

  task test_586();
    int s, k;
    logic [22:0] exp;
    clear();
    pulse_start(12'h586, s);
    wait_done(200);
    total++;
    if (done_cnt !== 1) $display("FAIL done_count_586 got %0d want 1", done_cnt); else passed++;
    total++;
    if (q_addr.size() !== 12) $display("FAIL addr_count_586 got %0d want 12", q_addr.size());
    else begin
      passed++;
      for (int r = 0; r < 6; r++) begin
        total++;
        if (q_addr[2*r] !== r || q_addr[2*r+1] !== 8 + r)
          $display("FAIL addr_586 row %0d got %0d,%0d want %0d,%0d", r, q_addr[2*r], q_addr[2*r+1], r, 8 + r);
        else passed++;
      end
    end
    total++;
    if (q_data.size() !== 30) $display("FAIL beat_count_586 got %0d want 30", q_data.size());
    else begin
      passed++;
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 5; c++) begin
          k = r * 5 + c;
          exp = {3'(r), 3'(c), ev((c / 4) * 8 + r, c % 4), k == 29};
          total++;
          if ({q_row[k], q_col[k], q_data[k], q_last[k]} !== exp)
            $display("FAIL beat_586[%0d] got %h want %h", k, {q_row[k], q_col[k], q_data[k], q_last[k]}, exp);
          else passed++;
        end
    end
    total++;
    if (done_cyc !== s + 55) $display("FAIL done_time_586 got %0d want %0d", done_cyc - s, 55); else passed++;
  endtask

  task test_empty();
    int s;
    clear();
    @(posedge clk); #1;
    mnt = 12'h044; start = 1; s = cyc;
    @(posedge clk); #1;
    mnt = 12'h444;
    @(posedge clk); #1;
    start = 0;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (done_cnt !== 1) $display("FAIL done_count_m0 got %0d want 1", done_cnt); else passed++;
    total++;
    if (done_cyc !== s + 1) $display("FAIL done_time_m0 got %0d want 1", done_cyc - s); else passed++;
    total++;
    if (q_addr.size() !== 0 || q_data.size() !== 0)
      $display("FAIL activity_m0 got %0d reads %0d beats want 0 0", q_addr.size(), q_data.size());
    else passed++;
    clear();
    pulse_start(12'h400, s);
    wait_done(20);
    total++;
    if (done_cnt !== 1 || q_addr.size() !== 0 || q_data.size() !== 0)
      $display("FAIL t0 got done %0d reads %0d beats %0d want 1 0 0", done_cnt, q_addr.size(), q_data.size());
    else passed++;
  endtask

  task test_stall();
    int s, stalls;
    int pat[4] = '{1, 0, 0, 1};
    logic [23:0] held, now;
    logic [22:0] exp;
    bit stalled;
    clear();
    stalled = 0;
    stalls = 0;
    pulse_start(12'h444, s);
    for (int k = 0; k < 400 && done_cnt == 0; k++) begin
      ready = pat[k % 4] != 0;
      @(negedge clk);
      now = {valid, data, row, col, last};
      if (stalled) begin
        stalls++;
        total++;
        if (now !== held) $display("FAIL stall_hold got %h want %h", now, held); else passed++;
      end
      stalled = valid && !ready;
      held = now;
      @(posedge clk); #1;
    end
    ready = 1;
    wait_done(10);
    total++;
    if (stalls == 0 || done_cnt !== 1) $display("FAIL stall_run got stalls %0d done %0d want >0 1", stalls, done_cnt);
    else passed++;
    total++;
    if (q_data.size() !== 16) $display("FAIL beat_count_stall got %0d want 16", q_data.size());
    else begin
      passed++;
      for (int k = 0; k < 16; k++) begin
        exp = {3'(k / 4), 3'(k % 4), ev(k / 4, k % 4), k == 15};
        total++;
        if ({q_row[k], q_col[k], q_data[k], q_last[k]} !== exp)
          $display("FAIL beat_stall[%0d] got %h want %h", k, {q_row[k], q_col[k], q_data[k], q_last[k]}, exp);
        else passed++;
      end
    end
  endtask

  task test_reset_mid();
    int s;
    clear();
    pulse_start(12'h444, s);
    for (int i = 0; i < 100 && !(valid && row == 3'd0 && col == 3'd2); i++) @(negedge clk);
    total++;
    if (!(valid && col == 3'd2)) $display("FAIL third_beat_seen got valid %b col %0d want 1 2", valid, col);
    else passed++;
    #1 rst = 1;
    #1;
    total++;
    if ({en, rw, addr, valid, data, row, col, last, busy, done} !== '0)
      $display("FAIL midreset_outputs got %0h want 0", {en, rw, addr, valid, data, row, col, last, busy, done});
    else passed++;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (done_cnt !== 0 || busy !== 1'b0) $display("FAIL midreset_nodone got done %0d busy %b want 0 0", done_cnt, busy);
    else passed++;
    clear();
    pulse_start(12'h444, s);
    wait_done(100);
    total++;
    if (q_addr.size() !== 4 || q_addr[0] !== 0) $display("FAIL restart_addr got %0d reads first %0d want 4 0", q_addr.size(), q_addr[0]);
    else passed++;
    total++;
    if (q_data.size() !== 16 || q_data[0] !== 16'hA000 || done_cnt !== 1)
      $display("FAIL restart_stream got %0d beats first %h done %0d want 16 a000 1", q_data.size(), q_data[0], done_cnt);
    else passed++;
  endtask

`ifdef OUT_DRAIN_PAD_CHECK_EN
  task test_pad();
    int s;
    logic [22:0] exp;
    mem[0] = {ev(0, 0), ev(0, 1), ev(0, 2), 16'h0001};
    clear();
    pulse_start(12'h322, s);
    for (int i = 0; i < 50 && !valid; i++) @(negedge clk);
    total++;
    if (err !== 1'b1) $display("FAIL err_set got %b want 1", err); else passed++;
    wait_done(100);
    total++;
    if (err !== 1'b1) $display("FAIL err_sticky got %b want 1", err); else passed++;
    total++;
    if (q_data.size() !== 6) $display("FAIL beat_count_pad got %0d want 6", q_data.size());
    else begin
      passed++;
      for (int k = 0; k < 6; k++) begin
        exp = {3'(k / 3), 3'(k % 3), ev(k / 3, k % 3), k == 5};
        total++;
        if ({q_row[k], q_col[k], q_data[k], q_last[k]} !== exp)
          $display("FAIL beat_pad[%0d] got %h want %h", k, {q_row[k], q_col[k], q_data[k], q_last[k]}, exp);
        else passed++;
      end
    end
    mem[0][15:0] = '0;
    mem[1][15:0] = '0;
    clear();
    pulse_start(12'h322, s);
    wait_done(100);
    total++;
    if (err !== 1'b0 || q_data.size() !== 6) $display("FAIL err_clear got err %b beats %0d want 0 6", err, q_data.size());
    else passed++;
  endtask
`endif

  initial begin
    for (int a = 0; a < 16; a++) mem[a] = {ev(a, 0), ev(a, 1), ev(a, 2), ev(a, 3)};
    test_reset();
    test_444();
    test_586();
    test_empty();
    test_stall();
    test_reset_mid();
`ifdef OUT_DRAIN_PAD_CHECK_EN
    test_pad();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
